// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and byte width.
package uart_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GUARD = 2'd1,
      ST_WAIT  = 2'd2
   } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Masked priority encoder: first set req bit scanning upward from ptr, with wrap-around.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [IDW-1:0]  sel,
   output logic            found
);

   function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int ofs);
      int sum;
      sum = int'(base) + ofs;
      if (sum >= NREQ) sum = sum - NREQ;
      return IDW'(sum);
   endfunction

   // Scan from the farthest offset down so the nearest hit is the one that sticks.
   always_comb begin
      sel   = '0;
      found = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req[wrap_add(ptr, k)]) begin
            sel   = wrap_add(ptr, k);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UartTx among NREQ byte requesters.
// Build option: UART_ARB_STRICT_PRIO_EN selects fixed lowest-index-wins priority.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic                   CLK,
   input  logic                   RST_X,
   input  logic [NREQ-1:0]        req,
   input  logic [BYTE_W*NREQ-1:0] req_data,
   output logic [NREQ-1:0]        ack,
   output logic                   tx_we,
   output logic [BYTE_W-1:0]      tx_data,
   input  logic                   tx_ready,
   output logic                   busy,
   output logic [IDW-1:0]         gnt_id
);

   arb_state_t          state, state_nxt;
   logic [IDW-1:0]      ptr, ptr_nxt;
   logic [NREQ-1:0]     ack_nxt;
   logic                we_nxt;
   logic [BYTE_W-1:0]   data_nxt;
   logic                busy_nxt;
   logic [IDW-1:0]      gnt_nxt;
   logic [IDW-1:0]      sel;
   logic                found;

   rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
      .req   (req),
      .ptr   (ptr),
      .sel   (sel),
      .found (found)
   );

   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         state   <= ST_IDLE;
         ptr     <= '0;
         ack     <= '0;
         tx_we   <= 1'b0;
         tx_data <= '0;
         busy    <= 1'b0;
         gnt_id  <= '0;
      end else begin
         state   <= state_nxt;
         ptr     <= ptr_nxt;
         ack     <= ack_nxt;
         tx_we   <= we_nxt;
         tx_data <= data_nxt;
         busy    <= busy_nxt;
         gnt_id  <= gnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      ack_nxt   = '0;
      we_nxt    = 1'b0;
      data_nxt  = tx_data;
      busy_nxt  = busy;
      gnt_nxt   = gnt_id;
      case (state)
         ST_IDLE: begin
            if (tx_ready && found) begin
               we_nxt       = 1'b1;
               data_nxt     = req_data[int'(sel)*BYTE_W +: BYTE_W];
               ack_nxt[sel] = 1'b1;
               gnt_nxt      = sel;
               busy_nxt     = 1'b1;
`ifdef UART_ARB_STRICT_PRIO_EN
               ptr_nxt      = '0;
`else
               ptr_nxt      = (int'(sel) == NREQ - 1) ? '0 : sel + 1'b1;
`endif
               state_nxt    = ST_GUARD;
            end
         end
         // UartTx still shows ready in this cycle; it drops one cycle after taking we.
         ST_GUARD: state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (tx_ready) begin
               busy_nxt  = 1'b0;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule
